// File: rtl/win3x3_seq_ctrl.sv
// Sequencer for the 3x3 neighbourhood stage: tracks input raster position, drives line-buffer
// writes, appends the bottom-pad flush and emits one registered window strobe per output pixel.
module win3x3_seq_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = $clog2(WIDTH + 1),
    parameter int YW     = $clog2(HEIGHT + 2)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    output logic          lb_wen,
    output logic          pad_beat,
    output logic          win_valid,
    output logic [XW-1:0] win_cx,
    output logic [YW-1:0] win_cy,
    output logic          edge_t,
    output logic          edge_b,
    output logic          edge_l,
    output logic          edge_r,
    output logic          win_sof,
    output logic          win_eof,
    output logic          frame_err,
    output logic          busy
);

    // state | meaning
    // IDLE  | waiting for an in_sof pixel; other pixels are dropped
    // RUN   | accepting the frame, one line-buffer beat per accepted pixel
    // FLUSH | WIDTH+1 pad beats (row HEIGHT, then (0,HEIGHT+1)) to drain the bottom windows
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [XW-1:0] COL_LAST   = XW'(WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST   = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] FLUSH_LOAD = XW'(WIDTH);

    state_t        state, state_nxt;
    logic [XW-1:0] col, col_nxt;
    logic [YW-1:0] row, row_nxt;
    logic [XW-1:0] flush_cnt, flush_nxt;
    logic [XW-1:0] beat_c;
    logic [YW-1:0] beat_r;
    logic          beat;
    logic          restart;
    logic          last_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        flush_nxt  = flush_cnt;
        in_ready   = 1'b1;
        beat       = 1'b0;
        pad_beat   = 1'b0;
        frame_err  = 1'b0;
        restart    = 1'b0;
        last_flush = 1'b0;
        beat_c     = col;
        beat_r     = row;
        case (state)
            IDLE: begin
                if (in_valid && in_sof) begin
                    beat      = 1'b1;
                    restart   = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    beat = 1'b1;
                    // a restart wins over FLUSH entry on the final pixel
                    if (in_sof) begin
                        restart   = 1'b1;
                        frame_err = 1'b1;
                    end else if (col == COL_LAST && row == ROW_LAST) begin
                        state_nxt = FLUSH;
                        flush_nxt = FLUSH_LOAD;
                    end
                end
            end
            FLUSH: begin
                in_ready = 1'b0;
                beat     = 1'b1;
                pad_beat = 1'b1;
                if (flush_cnt == '0) begin
                    last_flush = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    flush_nxt = flush_cnt - XW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (restart) begin
            beat_c = '0;
            beat_r = '0;
        end
    end

    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (beat) begin
            if (last_flush) begin
                col_nxt = '0;
                row_nxt = '0;
            end else if (beat_c == COL_LAST) begin
                col_nxt = '0;
                row_nxt = beat_r + YW'(1);
            end else begin
                col_nxt = beat_c + XW'(1);
                row_nxt = beat_r;
            end
        end
    end

    // Window lags its beat by one cycle to line up with line-buffer read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_cx    <= '0;
            win_cy    <= '0;
        end else begin
            win_valid <= 1'b0;
            if (beat) begin
                if (beat_c != '0 && beat_r != '0) begin
                    win_valid <= 1'b1;
                    win_cx    <= beat_c - XW'(1);
                    win_cy    <= beat_r - YW'(1);
                end else if (beat_c == '0 && beat_r >= YW'(2)) begin
                    win_valid <= 1'b1;
                    win_cx    <= COL_LAST;
                    win_cy    <= beat_r - YW'(2);
                end
            end
        end
    end

    assign lb_wen  = beat;
    assign busy    = (state != IDLE);
    assign edge_t  = win_valid && (win_cy == '0);
    assign edge_b  = win_valid && (win_cy == ROW_LAST);
    assign edge_l  = win_valid && (win_cx == '0);
    assign edge_r  = win_valid && (win_cx == COL_LAST);
    assign win_sof = edge_t && edge_l;
    assign win_eof = edge_b && edge_r;

endmodule

// File: tb/tb_win3x3_seq_ctrl.sv
// Randomised bench for win3x3_seq_ctrl: a linear-index frame model predicts beats and windows,
// a separate monitor pops expected windows and compares them as the DUT emits them.
module tb_win3x3_seq_ctrl;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int XW = $clog2(W + 1);
    localparam int YW = $clog2(H + 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sof = 1'b0;
    logic          in_ready, lb_wen, pad_beat, win_valid;
    logic [XW-1:0] win_cx;
    logic [YW-1:0] win_cy;
    logic          edge_t, edge_b, edge_l, edge_r, win_sof, win_eof, frame_err, busy;

    win3x3_seq_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .lb_wen(lb_wen), .pad_beat(pad_beat), .win_valid(win_valid),
        .win_cx(win_cx), .win_cy(win_cy), .edge_t(edge_t), .edge_b(edge_b),
        .edge_l(edge_l), .edge_r(edge_r), .win_sof(win_sof), .win_eof(win_eof),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int x;
        int y;
    } win_t;

    win_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame position as a linear beat index p = row*W + col.
    // A beat at index p yields the window with index p-W-1 one cycle later.
    int m_mode = 0;  // 0 idle, 1 run, 2 flush
    int m_p = 0;

    always @(negedge clk) begin : model
        int e_rdy, e_beat, e_pad, e_err, bi, idx;
        if (!rst_n) begin
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_lb_wen", int'(lb_wen), 0);
            chk("rst_pad_beat", int'(pad_beat), 0);
            chk("rst_win_valid", int'(win_valid), 0);
            chk("rst_frame_err", int'(frame_err), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_cxcy", int'(win_cx) + int'(win_cy), 0);
            m_mode = 0;
            m_p    = 0;
            exp_q.delete();
        end else begin
            e_rdy = 1; e_beat = 0; e_pad = 0; e_err = 0; bi = 0;
            chk("busy", int'(busy), int'(m_mode != 0));
            case (m_mode)
                0: begin
                    if (in_valid && in_sof) begin
                        e_beat = 1; bi = 0; m_mode = 1; m_p = 1;
                    end
                end
                1: begin
                    if (in_valid) begin
                        e_beat = 1;
                        if (in_sof) begin
                            e_err = 1; bi = 0; m_p = 1;
                        end else begin
                            bi = m_p;
                            m_p++;
                            if (bi == W * H - 1) m_mode = 2;
                        end
                    end
                end
                default: begin
                    e_rdy = 0; e_beat = 1; e_pad = 1; bi = m_p;
                    m_p++;
                    if (bi == (H + 1) * W) begin
                        m_mode = 0; m_p = 0;
                    end
                end
            endcase
            chk("in_ready", int'(in_ready), e_rdy);
            chk("lb_wen", int'(lb_wen), e_beat);
            chk("pad_beat", int'(pad_beat), e_pad);
            chk("frame_err", int'(frame_err), e_err);
            idx = bi - W - 1;
            if (e_beat != 0 && idx >= 0)
                exp_q.push_back('{due: cyc + 1, x: idx % W, y: idx / W});
        end
    end

    always @(negedge clk) begin : monitor
        win_t w;
        if (rst_n) begin
            if (win_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_window", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk("win_latency", cyc, w.due);
                    chk("win_cx", int'(win_cx), w.x);
                    chk("win_cy", int'(win_cy), w.y);
                    chk("edge_t", int'(edge_t), int'(w.y == 0));
                    chk("edge_b", int'(edge_b), int'(w.y == H - 1));
                    chk("edge_l", int'(edge_l), int'(w.x == 0));
                    chk("edge_r", int'(edge_r), int'(w.x == W - 1));
                    chk("win_sof", int'(win_sof), int'(w.x == 0 && w.y == 0));
                    chk("win_eof", int'(win_eof), int'(w.x == W - 1 && w.y == H - 1));
                end
            end else begin
                chk("flags_quiet", int'({edge_t, edge_b, edge_l, edge_r, win_sof, win_eof}), 0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    chk("missing_window", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // gmode: 0 continuous, 1 alternate valid, 2 random gaps. Stops early at stop_at pixels.
    task automatic send_frame(input int gmode, input int abort_at, input int stop_at);
        int   n = 0;
        int   guard = 0;
        int   ab = abort_at;
        logic acc;
        while (n < W * H && n != stop_at && guard < 200) begin
            guard++;
            case (gmode)
                0:       in_valid = 1'b1;
                1:       in_valid = ((guard % 2) == 1);
                default: in_valid = ($urandom_range(0, 99) < 70);
            endcase
            in_sof = in_valid && (n == 0 || n == ab);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (in_sof && n != 0) begin
                    n  = 1;
                    ab = -1;
                end else begin
                    n++;
                end
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (guard >= 200) chk("frame_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int done = 0;
        for (int i = 0; i < 60 && done == 0; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        @(posedge clk);
        #1;
        chk("idle_reached", done, 1);
    endtask

    task automatic reset_pulse();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic idle_junk(input int k);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int ab;
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;

        idle_junk(3);
        send_frame(0, -1, -1);
        wait_idle();
        send_frame(1, -1, -1);
        wait_idle();
        send_frame(0, 6, -1);
        wait_idle();
        // second frame's sof arrives while the first is flushing
        send_frame(2, -1, -1);
        send_frame(0, -1, -1);
        wait_idle();
        idle_junk(2);

        send_frame(0, -1, 7);
        reset_pulse();
        send_frame(0, -1, -1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_pulse();
        send_frame(2, -1, -1);
        wait_idle();

        for (int f = 0; f < 6; f++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W * H - 1)) : -1;
            send_frame(int'($urandom_range(0, 2)), ab, -1);
            if ($urandom_range(0, 1) == 1) idle_junk(int'($urandom_range(1, 3)));
        end
        wait_idle();
        repeat (3) begin
            @(posedge clk);
            #1;
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
